// File: rtl/seq_mult32.sv
// seq_mult32: sequential unsigned shift-and-add multiplier driving an external WIDTH-bit adder
// Ports: clk, rst_n (sync, active-low); start/a/b request and operands;
// busy (iterating), done (one-cycle result pulse), product (2*WIDTH result);
// add_a/add_b/add_cin to the external adder, add_sum/add_cout back from it.
module seq_mult32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_cin,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int MSB = WIDTH - 1;
  logic [1:0]       state;
  logic [WIDTH-1:0] mcand, hi, lo;
  logic [CNT_W-1:0] cnt;
  logic             run, last, cin_msb, c;
  logic             unused_cout;
  assign run         = state == RUN;
  assign busy        = run;
  assign done        = state == DONE;
  assign last        = cnt == CNT_W'(WIDTH - 1);
  assign add_a       = run ? hi : '0;
  assign add_b       = run && lo[0] ? mcand : '0;
  assign add_cin     = 1'b0;
  // The adder's Cout is the carry into its MSB, so the real carry-out is rebuilt here.
  assign cin_msb     = add_sum[MSB] ^ add_a[MSB] ^ add_b[MSB];
  assign c           = (add_a[MSB] & add_b[MSB]) | ((add_a[MSB] ^ add_b[MSB]) & cin_msb);
  assign unused_cout = add_cout;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      product <= '0;
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        mcand <= a;
        hi    <= '0;
        lo    <= b;
        cnt   <= '0;
        state <= RUN;
      end
    end else if (run) begin
      hi  <= {c, add_sum[WIDTH-1:1]};
      lo  <= {add_sum[0], lo[WIDTH-1:1]};
      cnt <= cnt + 1'b1;
      if (last) begin
        product <= {c, add_sum[WIDTH-1:1], add_sum[0], lo[WIDTH-1:1]};
        state   <= DONE;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: doc/seq_mult32.md
Name: seq_mult32

Overview:
- Sequential unsigned shift-and-add multiplier that computes a 2*WIDTH-bit product from two WIDTH-bit operands in WIDTH iterations.
- Owns no adder of its own. Drives the operand/carry inputs of the team's 32-bit carry-lookahead adder instance and consumes its Sum/Cout one iteration per clock.
- Sits directly upstream of that adder and downstream of the datapath issue logic, which supplies start/a/b.

Parameters:
- WIDTH, 32, operand width; must match the external adder width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  multiplicand, captured on accepted start.
- b  in  WIDTH  multiplier, captured on accepted start.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse when product is valid.
- product  out  2*WIDTH  result register.
- add_a  out  WIDTH  to adder A.
- add_b  out  WIDTH  to adder B.
- add_cin  out  1  to adder Cin; tied 0.
- add_sum  in  WIDTH  from adder Sum.
- add_cout  in  1  from adder carry-out. Note: the external adder's Cout is the carry into bit WIDTH-1. The block therefore ignores add_cout and recomputes the true carry-out internally as (add_a[MSB]&add_b[MSB]) | ((add_a[MSB]^add_b[MSB]) & carry_in_MSB), where carry_in_MSB = add_sum[MSB]^add_a[MSB]^add_b[MSB].

Behaviour:
- Reset: rst_n low at a rising edge gives state=IDLE, busy=0, done=0, product=0, hi=0, lo=0, mcand=0, cnt=0. This applies at any time, including mid-RUN; the partial result is discarded.
- Registers: mcand[WIDTH], hi[WIDTH], lo[WIDTH], cnt[CNT_W], state.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k gives mcand<=a, hi<=0, lo<=b, cnt<=0, state<=RUN.
  - start=0 keeps IDLE.
  - a and b are ignored except at acceptance.
- RUN (one iteration per cycle):
  - add_a=hi; add_b = lo[0] ? mcand : 0; add_cin=0.
  - c = internally computed carry-out.
  - At edge: hi<={c, add_sum[WIDTH-1:1]}, lo<={add_sum[0], lo[WIDTH-1:1]}, cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge: product<={c, add_sum[WIDTH-1:1], add_sum[0], lo[WIDTH-1:1]} (that is, the shifted {hi,lo}), state<=DONE.
- DONE: done=1 for exactly one cycle; the next edge returns to IDLE. start is ignored in DONE.
- busy=1 exactly when state==RUN (WIDTH cycles after edge k). busy is a registered state decode with no combinational path from start.
- Outputs in IDLE/DONE: add_a=0, add_b=0, add_cin=0.
- Latency: start accepted at edge k; product updated at edge k+WIDTH; done high during the cycle following edge k+WIDTH; earliest next acceptance at edge k+WIDTH+2.
- product holds its value until the next completion or reset. It is not cleared on a new start.
- start held high continuously: a new operation is accepted at each IDLE visit, giving one product every WIDTH+2 cycles.
- Arithmetic: unsigned only. Full-width result, no truncation or overflow flag. The maximum product (2^WIDTH-1)^2 fits in 2*WIDTH bits.
- Adder is combinational and assumed to settle within one clock. The block adds no pipelining on the adder path.

Test Plan:
- a=7, b=6, start pulse:
  - busy high 32 cycles;
  - done pulse at cycle 33 after acceptance;
  - product=0x0000_0000_0000_002A.
- a=0xFFFFFFFF, b=0xFFFFFFFF → product=0xFFFF_FFFE_0000_0001; this exercises the carry-out recompute on every iteration.
- Zero and boundary operands:
  - a=0x8000_0000, b=2 → product=0x0000_0001_0000_0000;
  - a=0x1234_5678, b=0 → product=0;
  - add_b must read 0 every RUN cycle.
- start pulsed while busy and during the DONE cycle with different a/b → ignored; the first product completes unchanged, and no second done occurs until a new start in IDLE.
- rst_n low for one edge at iteration 10 of a=5, b=9 → next cycle IDLE, busy=0, done=0, product=0; then a fresh a=5, b=9 start yields 45.
- start held high with a=3, b=3 → done pulses every 34 cycles, product=9 each time; add_cin is 0 throughout.
